pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Works alongside the EX-stage forwarding logic.
- Detects load-use hazards that forwarding cannot cover, and flushes on taken branches.
- Sequences the multi-cycle mul/div unit with a start/done handshake, freezing the front of the pipeline while the unit is busy.
- Provides a sticky mul/div timeout flag and a saturating stall counter for debug.

Parameters:
MD_TIMEOUT, 64, max cycles in MD_WAIT before forced release
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_Rs1_in  in  5  rs1 of instruction in ID
id_Rs2_in  in  5  rs2 of instruction in ID
id_uses_rs1_in  in  1  ID instruction reads rs1
id_uses_rs2_in  in  1  ID instruction reads rs2
ex_MemRead_in  in  1  EX instruction is a load
ex_Rd_in  in  5  rd of EX instruction
ex_branch_taken_in  in  1  branch/jump resolved taken in EX
ex_md_valid_in  in  1  EX holds a mul/div instruction
md_done_in  in  1  mul/div result valid (one-cycle pulse)
pc_stall_out  out  1  hold PC
ifid_stall_out  out  1  hold IF/ID register
idex_stall_out  out  1  hold ID/EX register
idex_bubble_out  out  1  load NOP into ID/EX
ifid_flush_out  out  1  clear IF/ID
idex_flush_out  out  1  clear ID/EX
exmem_bubble_out  out  1  load NOP into EX/MEM
md_start_out  out  1  mul/div start pulse
md_timeout_out  out  1  sticky timeout error
stall_cnt_out  out  CNT_W  saturating count of cycles with pc_stall_out=1

Behaviour:
Reset:
- rst_n=0 forces state IDLE, the timeout counter to 0, md_timeout_out=0 and stall_cnt_out=0.
- All combinational outputs evaluate with state=IDLE.
- Reset asserted mid mul/div abandons the operation; no md_start_out is reissued until ex_md_valid_in is seen again in IDLE.

FSM states:
- IDLE: if ex_md_valid_in=1, go to MD_START; else stay.
- MD_START: md_start_out=1 for exactly this cycle; always go to MD_WAIT.
- MD_WAIT:
  - md_done_in=1: go to MD_RELEASE.
  - Else, if the wait counter equals MD_TIMEOUT-1: set md_timeout_out and go to MD_RELEASE.
  - Else: increment the wait counter.
  - The wait counter clears on leaving MD_WAIT.
- MD_RELEASE: no freeze; EX/MEM captures the result; always go to IDLE. ex_md_valid_in is ignored here, which prevents restarting the same instruction.
- A back-to-back mul/div is seen in IDLE the next cycle and restarts the sequence: IDLE, MD_START, MD_WAIT, MD_RELEASE.
- md_done_in outside MD_WAIT is ignored.

md_freeze:
- Definition: (state=IDLE and ex_md_valid_in) or state=MD_START or state=MD_WAIT.
- When md_freeze=1: pc_stall_out, ifid_stall_out, idex_stall_out and exmem_bubble_out are all 1; idex_bubble_out, ifid_flush_out and idex_flush_out are all 0.

load_use:
- Definition: ex_MemRead_in and ex_Rd_in≠0 and ((id_uses_rs1_in and id_Rs1_in=ex_Rd_in) or (id_uses_rs2_in and id_Rs2_in=ex_Rd_in)).

Output priority (all stall/flush outputs combinational, same cycle):
1. md_freeze: outputs as listed above. A taken branch cannot coexist with a mul/div in EX; if both are asserted, md_freeze wins.
2. ex_branch_taken_in: ifid_flush_out=1 and idex_flush_out=1; no stall, even if load_use.
3. load_use: pc_stall_out=1, ifid_stall_out=1, idex_bubble_out=1. Exactly one bubble, because next cycle the load has moved to MEM.
4. Otherwise all stall/flush outputs are 0.

Registered outputs:
- md_timeout_out is sticky until reset.
- stall_cnt_out increments on each clock edge where pc_stall_out=1 and saturates at 2^CNT_W-1 (no wrap).

Test Plan:
- Load-use: ex_MemRead=1, ex_Rd=5, id_Rs2=5, id_uses_rs2=1 for one cycle → pc_stall, ifid_stall and idex_bubble are 1 that cycle only; stall_cnt goes 0→1.
- Load writing x0, or rs not used: ex_Rd=0 with id_Rs1=0; then ex_Rd=7, id_Rs1=7, id_uses_rs1=0 → no stall in either case.
- Branch beats load-use: ex_branch_taken=1 with a load-use match → ifid_flush=1, idex_flush=1, pc_stall=0.
- Mul/div handshake: ex_md_valid=1 held; md_done pulses 4 cycles after md_start → one md_start pulse; freeze lasts 6 cycles (IDLE, MD_START, 4 in MD_WAIT); MD_RELEASE has no freeze; stall_cnt=6; back-to-back mul/div gives a second md_start.
- Timeout: MD_TIMEOUT=8, md_done never asserted → release after 8 MD_WAIT cycles; md_timeout_out=1 stays high; rst_n low mid-MD_WAIT clears it, state returns to IDLE and outputs go to 0.
- Saturation: CNT_W=4 with pc_stall held for 20 cycles → stall_cnt_out stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Load-use and branch-flush arbitration plus the mul/div start/done sequencer.
module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_Rs1_in,
  input  logic [4:0]       id_Rs2_in,
  input  logic             id_uses_rs1_in,
  input  logic             id_uses_rs2_in,
  input  logic             ex_MemRead_in,
  input  logic [4:0]       ex_Rd_in,
  input  logic             ex_branch_taken_in,
  input  logic             ex_md_valid_in,
  input  logic             md_done_in,
  output logic             pc_stall_out,
  output logic             ifid_stall_out,
  output logic             idex_stall_out,
  output logic             idex_bubble_out,
  output logic             ifid_flush_out,
  output logic             idex_flush_out,
  output logic             exmem_bubble_out,
  output logic             md_start_out,
  output logic             md_timeout_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  localparam int WAIT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MD_START   = 2'd1,
    MD_WAIT    = 2'd2,
    MD_RELEASE = 2'd3
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              md_freeze;
  logic              rs1_hit;
  logic              rs2_hit;

  always_comb begin
    rs1_hit   = id_uses_rs1_in && (id_Rs1_in == ex_Rd_in);
    rs2_hit   = id_uses_rs2_in && (id_Rs2_in == ex_Rd_in);
    load_use  = ex_MemRead_in && (ex_Rd_in != 5'd0) && (rs1_hit || rs2_hit);
    md_freeze = ((state == IDLE) && ex_md_valid_in) ||
                (state == MD_START) || (state == MD_WAIT);
  end

  // Freeze outranks a branch, which outranks a load-use bubble.
  always_comb begin
    pc_stall_out     = 1'b0;
    ifid_stall_out   = 1'b0;
    idex_stall_out   = 1'b0;
    idex_bubble_out  = 1'b0;
    ifid_flush_out   = 1'b0;
    idex_flush_out   = 1'b0;
    exmem_bubble_out = 1'b0;
    if (md_freeze) begin
      pc_stall_out     = 1'b1;
      ifid_stall_out   = 1'b1;
      idex_stall_out   = 1'b1;
      exmem_bubble_out = 1'b1;
    end else if (ex_branch_taken_in) begin
      ifid_flush_out = 1'b1;
      idex_flush_out = 1'b1;
    end else if (load_use) begin
      pc_stall_out    = 1'b1;
      ifid_stall_out  = 1'b1;
      idex_bubble_out = 1'b1;
    end
  end

  // md_start_out is registered: high exactly while the FSM sits in MD_START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      md_start_out   <= 1'b0;
      md_timeout_out <= 1'b0;
    end else begin
      md_start_out <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_md_valid_in) begin
            state        <= MD_START;
            md_start_out <= 1'b1;
          end
        end
        MD_START: begin
          state    <= MD_WAIT;
          wait_cnt <= '0;
        end
        MD_WAIT: begin
          if (md_done_in) begin
            state    <= MD_RELEASE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state          <= MD_RELEASE;
            wait_cnt       <= '0;
            md_timeout_out <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        MD_RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_out <= '0;
    end else if (pc_stall_out && (stall_cnt_out != CNT_MAX)) begin
      stall_cnt_out <= stall_cnt_out + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and random checks against a behavioural model
module tb_pipeline_hazard_ctrl;

  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_Rs1_in, id_Rs2_in, ex_Rd_in;
  logic          id_uses_rs1_in, id_uses_rs2_in, ex_MemRead_in;
  logic          ex_branch_taken_in, ex_md_valid_in, md_done_in;
  logic          pc_stall_out, ifid_stall_out, idex_stall_out, idex_bubble_out;
  logic          ifid_flush_out, idex_flush_out, exmem_bubble_out;
  logic          md_start_out, md_timeout_out;
  logic [CW-1:0] stall_cnt_out;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_Rs1_in(id_Rs1_in), .id_Rs2_in(id_Rs2_in),
    .id_uses_rs1_in(id_uses_rs1_in), .id_uses_rs2_in(id_uses_rs2_in),
    .ex_MemRead_in(ex_MemRead_in), .ex_Rd_in(ex_Rd_in),
    .ex_branch_taken_in(ex_branch_taken_in), .ex_md_valid_in(ex_md_valid_in),
    .md_done_in(md_done_in),
    .pc_stall_out(pc_stall_out), .ifid_stall_out(ifid_stall_out),
    .idex_stall_out(idex_stall_out), .idex_bubble_out(idex_bubble_out),
    .ifid_flush_out(ifid_flush_out), .idex_flush_out(idex_flush_out),
    .exmem_bubble_out(exmem_bubble_out), .md_start_out(md_start_out),
    .md_timeout_out(md_timeout_out), .stall_cnt_out(stall_cnt_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: an operation is "active" from its start cycle through its last wait cycle;
  // age 0 is the start cycle, age k>=1 is the k-th wait cycle. rel marks the release cycle.
  bit m_active, m_rel, m_tmo;
  int m_age, m_cnt;
  bit obs_pc, obs_start;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    id_Rs1_in = 0; id_Rs2_in = 0; ex_Rd_in = 0;
    id_uses_rs1_in = 0; id_uses_rs2_in = 0; ex_MemRead_in = 0;
    ex_branch_taken_in = 0; ex_md_valid_in = 0; md_done_in = 0;
  endtask

  task automatic model_reset();
    m_active = 0; m_rel = 0; m_tmo = 0; m_age = 0; m_cnt = 0;
  endtask

  // Inputs are set just after a negedge; check, then advance one clock.
  task automatic step();
    bit lu, fr, br, e_pc;
    #1;
    lu = ex_MemRead_in && ex_Rd_in != 0 &&
         ((id_uses_rs1_in && id_Rs1_in == ex_Rd_in) || (id_uses_rs2_in && id_Rs2_in == ex_Rd_in));
    fr = m_active || (!m_rel && ex_md_valid_in);
    br = ex_branch_taken_in;
    e_pc = fr || (!br && lu);
    check_eq("pc_stall", pc_stall_out, e_pc);
    check_eq("ifid_stall", ifid_stall_out, e_pc);
    check_eq("idex_stall", idex_stall_out, fr);
    check_eq("idex_bubble", idex_bubble_out, !fr && !br && lu);
    check_eq("ifid_flush", ifid_flush_out, !fr && br);
    check_eq("idex_flush", idex_flush_out, !fr && br);
    check_eq("exmem_bubble", exmem_bubble_out, fr);
    check_eq("md_start", md_start_out, m_active && m_age == 0);
    check_eq("md_timeout", md_timeout_out, m_tmo);
    check_eq("stall_cnt", stall_cnt_out, m_cnt);
    obs_pc = pc_stall_out;
    obs_start = md_start_out;
    @(posedge clk);
    if (e_pc && m_cnt < (1 << CW) - 1) m_cnt++;
    if (m_rel) m_rel = 0;
    else if (!m_active) begin
      if (ex_md_valid_in) begin m_active = 1; m_age = 0; end
    end else if (m_age == 0) m_age = 1;
    else if (md_done_in || m_age == TO) begin
      if (!md_done_in) m_tmo = 1;
      m_active = 0; m_rel = 1;
    end else m_age++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check_eq("rst_pc_stall", pc_stall_out, 0);
    check_eq("rst_exmem_bubble", exmem_bubble_out, 0);
    check_eq("rst_md_start", md_start_out, 0);
    check_eq("rst_md_timeout", md_timeout_out, 0);
    check_eq("rst_stall_cnt", stall_cnt_out, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int pcs, starts;
    clear_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Load-use through rs2
    ex_MemRead_in = 1; ex_Rd_in = 5; id_Rs2_in = 5; id_uses_rs2_in = 1;
    step();
    check_eq("lu_stall", obs_pc, 1);
    clear_inputs();
    step();
    check_eq("lu_one_cycle", obs_pc, 0);
    check_eq("lu_cnt", stall_cnt_out, 1);

    // Load to x0, then unused source
    ex_MemRead_in = 1; ex_Rd_in = 0; id_Rs1_in = 0; id_uses_rs1_in = 1;
    step();
    check_eq("lu_x0", obs_pc, 0);
    ex_Rd_in = 7; id_Rs1_in = 7; id_uses_rs1_in = 0;
    step();
    check_eq("lu_unused", obs_pc, 0);

    // Branch over load-use
    ex_Rd_in = 3; id_Rs1_in = 3; id_uses_rs1_in = 1; ex_branch_taken_in = 1;
    #1;
    check_eq("br_ifid_flush", ifid_flush_out, 1);
    check_eq("br_idex_flush", idex_flush_out, 1);
    check_eq("br_no_stall", pc_stall_out, 0);
    step();
    clear_inputs();

    // Mul/div handshake, done 4 cycles after start, back-to-back follow-up
    do_reset();
    pcs = 0; starts = 0;
    ex_md_valid_in = 1;
    for (int c = 0; c < 7; c++) begin
      md_done_in = (c == 5);
      step();
      pcs += obs_pc; starts += obs_start;
      if (c == 6) check_eq("md_release_nofreeze", obs_pc, 0);
    end
    check_eq("md_freeze_cycles", pcs, 6);
    check_eq("md_one_start", starts, 1);
    check_eq("md_stall_cnt", stall_cnt_out, 6);
    step();
    step();
    check_eq("md_b2b_start", obs_start, 1);
    clear_inputs();

    // Timeout after 8 wait cycles, sticky
    do_reset();
    pcs = 0;
    ex_md_valid_in = 1;
    step(); pcs += obs_pc;
    ex_md_valid_in = 0;
    for (int c = 0; c < 9 + 3; c++) begin step(); pcs += obs_pc; end
    check_eq("to_freeze_cycles", pcs, 10);
    check_eq("to_sticky", md_timeout_out, 1);
    check_eq("to_stall_cnt", stall_cnt_out, 10);

    // Reset during wait abandons the operation
    ex_md_valid_in = 1;
    step();
    ex_md_valid_in = 0;
    for (int c = 0; c < 4; c++) step();
    clear_inputs();
    do_reset();
    starts = 0;
    for (int c = 0; c < 5; c++) begin step(); starts += obs_start; end
    check_eq("rst_no_restart", starts, 0);

    // Saturation
    ex_MemRead_in = 1; ex_Rd_in = 9; id_Rs1_in = 9; id_uses_rs1_in = 1;
    for (int c = 0; c < 20; c++) step();
    check_eq("sat_cnt", stall_cnt_out, 15);
    clear_inputs();

    // Random traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin clear_inputs(); do_reset(); end
      id_Rs1_in = 5'($urandom_range(0, 3));
      id_Rs2_in = 5'($urandom_range(0, 3));
      ex_Rd_in = 5'($urandom_range(0, 3));
      id_uses_rs1_in = 1'($urandom);
      id_uses_rs2_in = 1'($urandom);
      ex_MemRead_in = 1'($urandom);
      ex_branch_taken_in = ($urandom_range(0, 4) == 0);
      ex_md_valid_in = ($urandom_range(0, 3) == 0);
      md_done_in = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
